alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

- Sequencer in front of the shared 16-bit ALU (16 ripple-connected 1-bit slices).
- Accepts one operation at a time over a valid/ready handshake:
  - single-cycle ALU op,
  - unsigned 16×16→32 multiply (shift-add),
  - unsigned 16/16 divide (restoring).
- Drives the ALU's A, B, ALUCtrl, BInvert and carry-in every cycle, and holds the result until the consumer takes it.

## Interface
- `W`, 16: datapath width; the iteration count equals `W`.
- `CLK` in 1: rising-edge clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `REQ_VALID` in 1: request present.
- `REQ_READY` out 1: sequencer can accept a request.
- `REQ_OP` in 2: `00` ALU, `01` MUL, `10` DIV, `11` illegal.
- `REQ_FUNC` in 3: ALUCtrl code for OP=`00`.
- `REQ_BINV` in 1: BInvert for OP=`00`; it also drives carry-in.
- `REQ_A`, `REQ_B` in W: operands.
- `RSP_VALID` out 1: response held.
- `RSP_READY` in 1: consumer accepts the response.
- `RSP_LO` out W: ALU result, product[15:0], or quotient.
- `RSP_HI` out W: 0, product[31:16], or remainder.
- `RSP_COUT` out 1: ALU carry-out for OP=`00`, else 0.
- `RSP_ERR` out 1: illegal op or divide by zero.
- `ALU_A`, `ALU_B` out W: ALU operands.
- `ALU_CTRL` out 3: ALU function select. `000` AND, `001` OR, `010` ADD, `011` XOR, `101` LESS.
- `ALU_BINV` out 1: ALU B-invert.
- `ALU_CIN` out 1: carry-in to bit 0.
- `ALU_REZ` in W: ALU result.
- `ALU_COUT` in 1: carry-out from bit W-1.

## Operation

**States:** IDLE, EXEC, MUL, DIV, DONE.
- `REQ_READY` = 1 only in IDLE.
- A request is accepted on `REQ_VALID & REQ_READY`. The operands, op, func and binv are registered at accept.

**Accept transitions** (from IDLE):
- OP=`00` → EXEC.
- OP=`01` → MUL, with iteration counter = 0.
- OP=`10`, B≠0 → DIV, with counter = 0.
- OP=`10`, B=0 → DONE with `RSP_LO`=0xFFFF, `RSP_HI`=A, `RSP_ERR`=1.
- OP=`11` → DONE with `RSP_LO`=`RSP_HI`=0, `RSP_ERR`=1.

**EXEC:**
- ALU is driven with {A, B, FUNC, BINV, CIN=BINV}.
- `ALU_REZ`/`ALU_COUT` are captured into `RSP_LO`/`RSP_COUT`; `RSP_HI`=0.
- → DONE.

**MUL:**
- Registers: acc_hi (init 0), acc_lo (init A), multiplicand M=B.
- ALU is driven with {acc_hi, M, ADD, BINV=0, CIN=0}.
- Per cycle:
  - If acc_lo[0]=1: {c, s} = {`ALU_COUT`, `ALU_REZ`}.
  - Else: {c, s} = {0, acc_hi}.
  - Then {acc_hi, acc_lo} ← {c, s, acc_lo[15:1]}.
- After W cycles → DONE with {`RSP_HI`, `RSP_LO`} = {acc_hi, acc_lo}.

**DIV:**
- Registers: rem (init 0), quo (init A), divisor D=B.
- Per cycle:
  - Shifted value t = {rem[14:0], quo[15]}; msb = rem[15].
  - ALU is driven with {t, D, ADD, BINV=1, CIN=1}.
  - ok = `ALU_COUT` | msb.
  - rem ← ok ? `ALU_REZ` : t.
  - quo ← {quo[14:0], ok}.
- After W cycles → DONE with `RSP_LO`=quo, `RSP_HI`=rem.

**DONE:**
- `RSP_VALID`=1; the response registers are stable.
- On `RSP_READY` → IDLE.

**Idle ALU drive:** in IDLE and DONE the ALU outputs are all 0 (AND of zeros).

**Reset:**
- State = IDLE; all response and ALU outputs = 0.
- `REQ_READY` = 1 after reset release.
- Reset asserted mid-MUL/DIV aborts the operation; no response is produced.

## Timing
- Request accepted at edge t:
  - OP=`00`: `RSP_VALID` from t+2.
  - MUL/DIV: `RSP_VALID` from t+1+W (t+17).
  - Divide by zero / illegal: `RSP_VALID` from t+1.
- `RSP_VALID` and the data are held until `RSP_READY` is sampled high. `REQ_READY` returns at the edge following that handshake, so there is no accept in the same cycle as a response.
- ALU outputs are registered-state-driven. The ALU path (combinational ripple) must close within one `CLK` period.
- `REQ_*` inputs are ignored outside IDLE.

## Configuration
- `ALU_SEQ_DIV_EN`
  - Defined: DIV state and divider datapath present.
  - Undefined: DIV logic is removed and OP=`10` is handled as illegal (`RSP_ERR`=1, results 0, t+1).

## Structure
- Shared package `alu_pkg` holds:
  - the state enum;
  - op codes `OP_ALU`/`OP_MUL`/`OP_DIV`/`OP_ILL`;
  - ALUCtrl constants `ALU_AND`/`ALU_OR`/`ALU_ADD`/`ALU_XOR`/`ALU_LESS`;
  - `W`.
- One sub-module, `alu_seq_fsm`: the state register, iteration counter and done detection.
- The datapath registers stay in `alu_seq_ctrl`.

## Test plan
- OP=`00`, FUNC=ADD, BINV=0, A=0xFFFF, B=0x0001 → `RSP_LO`=0x0000, `RSP_COUT`=1, `RSP_VALID` at t+2.
- OP=`01`, A=0xFFFF, B=0xFFFF → {`RSP_HI`, `RSP_LO`}=0xFFFE_0001, `RSP_VALID` at t+17, `REQ_READY`=0 for t+1..t+17.
- OP=`10`, A=0xFFFF, B=0x0007 → `RSP_LO`=0x2492, `RSP_HI`=0x0001. Also A=0x8000, B=0x8001 → `RSP_LO`=0, `RSP_HI`=0x8000 (exercises the msb path).
- OP=`10`, B=0 → `RSP_ERR`=1, `RSP_LO`=0xFFFF, `RSP_HI`=A at t+1. Without `ALU_SEQ_DIV_EN`, any DIV → `RSP_ERR`=1, results 0.
- Hold `RSP_READY`=0 for 5 cycles after MUL done → response stable and `REQ_READY`=0 throughout; `RSP_READY` pulse → IDLE.
- Assert `RST_N`=0 at iteration 8 of MUL → all outputs 0 immediately. After release, no `RSP_VALID` and `REQ_READY`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: state encoding, op codes,
// ALUCtrl function codes and the datapath width.
package alu_pkg;

   localparam int W     = 16;
   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_LESS = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXEC = 3'd1,
      ST_MUL  = 3'd2,
      ST_DIV  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and the
// ALU sequencer (slave).
interface alu_seq_ctrl_if;

   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             req_op;
   logic [2:0]             req_func;
   logic                   req_binv;
   logic [alu_pkg::W-1:0]  req_a;
   logic [alu_pkg::W-1:0]  req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [alu_pkg::W-1:0]  rsp_lo;
   logic [alu_pkg::W-1:0]  rsp_hi;
   logic                   rsp_cout;
   logic                   rsp_err;

   modport master (
      output req_valid, req_op, req_func, req_binv, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cout, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_func, req_binv, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_cout, rsp_err
   );

endinterface

// File: rtl/alu_seq_fsm.sv
// Sequencer control: state register, iteration counter, done detection and the
// registered handshake outputs. Macro ALU_SEQ_DIV_EN enables the DIV state.
module alu_seq_fsm
   import alu_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_accept,
   input  logic [1:0]       i_op,
   input  logic             i_err,
   input  logic             i_rsp_ready,
   output state_t           o_state,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last,
   output logic             o_req_ready,
   output logic             o_rsp_valid
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req_ready;
   logic             r_rsp_valid;
   logic             w_last;

   assign w_last = (r_cnt == LAST_CNT);

   // Single-process FSM; handshake flags are updated alongside the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_accept) begin
                  r_req_ready <= 1'b0;
                  r_cnt       <= {CNT_W{1'b0}};
                  if (i_err) begin
                     r_state     <= ST_DONE;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     case (i_op)
                        OP_ALU: r_state <= ST_EXEC;
                        OP_MUL: r_state <= ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV: r_state <= ST_DIV;
`endif
                        default: begin
                           r_state     <= ST_DONE;
                           r_rsp_valid <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            ST_EXEC: begin
               r_state     <= ST_DONE;
               r_rsp_valid <= 1'b1;
            end
            ST_MUL: begin
               r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (w_last) begin
                  r_state     <= ST_DONE;
                  r_rsp_valid <= 1'b1;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
               r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (w_last) begin
                  r_state     <= ST_DONE;
                  r_rsp_valid <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               if (i_rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_state     = r_state;
   assign o_cnt       = r_cnt;
   assign o_last      = w_last;
   assign o_req_ready = r_req_ready;
   assign o_rsp_valid = r_rsp_valid;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of a shared W-bit ripple ALU: single ALU ops, shift-add
// multiply and (with macro ALU_SEQ_DIV_EN) restoring divide.
module alu_seq_ctrl
   import alu_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   alu_seq_ctrl_if.slave       bus,
   output logic [W-1:0]        o_alu_a,
   output logic [W-1:0]        o_alu_b,
   output logic [2:0]          o_alu_ctrl,
   output logic                o_alu_binv,
   output logic                o_alu_cin,
   input  logic [W-1:0]        i_alu_rez,
   input  logic                i_alu_cout
);

   state_t           w_state;
   logic [CNT_W-1:0] w_cnt;
   logic             w_last;
   logic             w_req_ready;
   logic             w_rsp_valid;
   logic             w_accept;
   logic             w_err;

   // r_a: operand A / acc_lo / quotient; r_hi: acc_hi / remainder; r_b: B / M / D.
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_hi;
   logic [2:0]       r_func;
   logic             r_binv;
   logic [W-1:0]     r_rsp_lo;
   logic [W-1:0]     r_rsp_hi;
   logic             r_rsp_cout;
   logic             r_rsp_err;

   logic             w_mul_c;
   logic [W-1:0]     w_mul_s;
   logic [W-1:0]     w_mul_hi;
   logic [W-1:0]     w_mul_lo;

   logic [W-1:0]     w_alu_a;
   logic [W-1:0]     w_alu_b;
   logic [2:0]       w_alu_ctrl;
   logic             w_alu_binv;
   logic             w_alu_cin;

   assign w_accept = bus.req_valid & w_req_ready;

`ifdef ALU_SEQ_DIV_EN
   logic             w_div_zero;
   logic [W-1:0]     w_div_t;
   logic             w_div_ok;
   assign w_div_zero = (bus.req_op == OP_DIV) && (bus.req_b == {W{1'b0}});
   assign w_err      = (bus.req_op == OP_ILL) | w_div_zero;
   assign w_div_t    = {r_hi[W-2:0], r_a[W-1]};
   // A set msb means the 17-bit partial remainder already exceeds any divisor.
   assign w_div_ok   = i_alu_cout | r_hi[W-1];
`else
   assign w_err      = (bus.req_op == OP_ILL) | (bus.req_op == OP_DIV);
`endif

   assign w_mul_c  = r_a[0] ? i_alu_cout : 1'b0;
   assign w_mul_s  = r_a[0] ? i_alu_rez  : r_hi;
   assign w_mul_hi = {w_mul_c, w_mul_s[W-1:1]};
   assign w_mul_lo = {w_mul_s[0], r_a[W-1:1]};

   alu_seq_fsm u_fsm (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_accept    (w_accept),
      .i_op        (bus.req_op),
      .i_err       (w_err),
      .i_rsp_ready (bus.rsp_ready),
      .o_state     (w_state),
      .o_cnt       (w_cnt),
      .o_last      (w_last),
      .o_req_ready (w_req_ready),
      .o_rsp_valid (w_rsp_valid)
   );

   // ALU drive decoded from registered state; zeros (AND of zeros) when not computing.
   always_comb begin
      w_alu_a    = {W{1'b0}};
      w_alu_b    = {W{1'b0}};
      w_alu_ctrl = ALU_AND;
      w_alu_binv = 1'b0;
      w_alu_cin  = 1'b0;
      case (w_state)
         ST_EXEC: begin
            w_alu_a    = r_a;
            w_alu_b    = r_b;
            w_alu_ctrl = r_func;
            w_alu_binv = r_binv;
            w_alu_cin  = r_binv;
         end
         ST_MUL: begin
            w_alu_a    = r_hi;
            w_alu_b    = r_b;
            w_alu_ctrl = ALU_ADD;
         end
`ifdef ALU_SEQ_DIV_EN
         ST_DIV: begin
            w_alu_a    = w_div_t;
            w_alu_b    = r_b;
            w_alu_ctrl = ALU_ADD;
            w_alu_binv = 1'b1;
            w_alu_cin  = 1'b1;
         end
`endif
         default: w_alu_ctrl = ALU_AND;
      endcase
   end

   // Operand/accumulator registers and the held response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a        <= {W{1'b0}};
         r_b        <= {W{1'b0}};
         r_hi       <= {W{1'b0}};
         r_func     <= 3'b000;
         r_binv     <= 1'b0;
         r_rsp_lo   <= {W{1'b0}};
         r_rsp_hi   <= {W{1'b0}};
         r_rsp_cout <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else if (w_accept) begin
         r_a        <= bus.req_a;
         r_b        <= bus.req_b;
         r_hi       <= {W{1'b0}};
         r_func     <= bus.req_func;
         r_binv     <= bus.req_binv;
         r_rsp_cout <= 1'b0;
         r_rsp_err  <= w_err;
         r_rsp_lo   <= {W{1'b0}};
         r_rsp_hi   <= {W{1'b0}};
`ifdef ALU_SEQ_DIV_EN
         if (w_div_zero) begin
            r_rsp_lo <= {W{1'b1}};
            r_rsp_hi <= bus.req_a;
         end
`endif
      end else begin
         case (w_state)
            ST_EXEC: begin
               r_rsp_lo   <= i_alu_rez;
               r_rsp_hi   <= {W{1'b0}};
               r_rsp_cout <= i_alu_cout;
            end
            ST_MUL: begin
               r_hi <= w_mul_hi;
               r_a  <= w_mul_lo;
               if (w_last) begin
                  r_rsp_hi <= w_mul_hi;
                  r_rsp_lo <= w_mul_lo;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_DIV: begin
               r_hi <= w_div_ok ? i_alu_rez : w_div_t;
               r_a  <= {r_a[W-2:0], w_div_ok};
               if (w_last) begin
                  r_rsp_hi <= w_div_ok ? i_alu_rez : w_div_t;
                  r_rsp_lo <= {r_a[W-2:0], w_div_ok};
               end
            end
`endif
            ST_DONE: begin
               if (bus.rsp_ready) begin
                  r_rsp_lo   <= {W{1'b0}};
                  r_rsp_hi   <= {W{1'b0}};
                  r_rsp_cout <= 1'b0;
                  r_rsp_err  <= 1'b0;
               end
            end
            default: r_binv <= r_binv;
         endcase
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_lo    = r_rsp_lo;
   assign bus.rsp_hi    = r_rsp_hi;
   assign bus.rsp_cout  = r_rsp_cout;
   assign bus.rsp_err   = r_rsp_err;

   assign o_alu_a    = w_alu_a;
   assign o_alu_b    = w_alu_b;
   assign o_alu_ctrl = w_alu_ctrl;
   assign o_alu_binv = w_alu_binv;
   assign o_alu_cin  = w_alu_cin;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural ripple ALU
// attached; expectations follow ALU_SEQ_DIV_EN when it is defined.
module tb_alu_seq_ctrl;
   import alu_pkg::*;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  alu_a, alu_b, alu_rez;
   logic [2:0]    alu_ctrl;
   logic          alu_binv, alu_cin, alu_cout;
   logic [W-1:0]  m_b;
   logic [W:0]    m_sum;
   int            n_cmp;
   int            n_err;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .bus        (bus),
      .o_alu_a    (alu_a),
      .o_alu_b    (alu_b),
      .o_alu_ctrl (alu_ctrl),
      .o_alu_binv (alu_binv),
      .o_alu_cin  (alu_cin),
      .i_alu_rez  (alu_rez),
      .i_alu_cout (alu_cout)
   );

   // Behavioural stand-in for the 16-slice ripple ALU.
   assign m_b      = alu_binv ? ~alu_b : alu_b;
   assign m_sum    = {1'b0, alu_a} + {1'b0, m_b} + {{W{1'b0}}, alu_cin};
   assign alu_cout = m_sum[W];
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_rez = alu_a & m_b;
         3'b001:  alu_rez = alu_a | m_b;
         3'b010:  alu_rez = m_sum[W-1:0];
         3'b011:  alu_rez = alu_a ^ m_b;
         3'b101:  alu_rez = {{(W-1){1'b0}}, m_sum[W-1]};
         default: alu_rez = {W{1'b0}};
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge with the sequencer idle; returns just after the accept edge.
   task automatic send(input logic [1:0] op, input logic [2:0] func, input logic binv,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      bus.req_op    = op;
      bus.req_func  = func;
      bus.req_binv  = binv;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Counts accept-to-valid edges (bounded); notes any REQ_READY seen while busy.
   task automatic wait_rsp(output int lat, output logic rdy_seen);
      lat = 0;
      rdy_seen = 1'b0;
      @(negedge clk);
      rdy_seen = bus.req_ready;
      while (!bus.rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         rdy_seen = rdy_seen | bus.req_ready;
      end
   endtask

   task automatic take_rsp;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_cout, bus.rsp_lo, bus.rsp_hi} !== 35'd0) begin
         n_err++;
         $display("FAIL reset_rsp got v=%b e=%b c=%b lo=%h hi=%h want all 0", bus.rsp_valid, bus.rsp_err, bus.rsp_cout, bus.rsp_lo, bus.rsp_hi);
      end
      n_cmp++;
      if ({alu_a, alu_b, alu_ctrl, alu_binv, alu_cin} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_alu got a=%h b=%h ctrl=%b binv=%b cin=%b want all 0", alu_a, alu_b, alu_ctrl, alu_binv, alu_cin);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release got ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_alu;
      int lat; logic rdy;
      send(OP_ALU, ALU_ADD, 1'b0, 16'hFFFF, 16'h0001);
      @(negedge clk);
      n_cmp++;
      if (alu_a !== 16'hFFFF || alu_b !== 16'h0001 || alu_ctrl !== ALU_ADD || alu_cin !== 1'b0) begin
         n_err++;
         $display("FAIL alu_drive got a=%h b=%h ctrl=%b cin=%b want ffff 0001 010 0", alu_a, alu_b, alu_ctrl, alu_cin);
      end
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL alu_early_valid got %b want 0", bus.rsp_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 16'h0000 || bus.rsp_hi !== 16'h0000 || bus.rsp_cout !== 1'b1 || bus.rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL alu_add got v=%b lo=%h hi=%h c=%b e=%b want 1 0000 0000 1 0", bus.rsp_valid, bus.rsp_lo, bus.rsp_hi, bus.rsp_cout, bus.rsp_err);
      end
      n_cmp++;
      if ({alu_a, alu_b, alu_ctrl} !== 35'd0) begin
         n_err++;
         $display("FAIL alu_done_drive got a=%h b=%h ctrl=%b want 0", alu_a, alu_b, alu_ctrl);
      end
      take_rsp();
      send(OP_ALU, ALU_ADD, 1'b1, 16'h0005, 16'h0007);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 1 || bus.rsp_lo !== 16'hFFFE || bus.rsp_cout !== 1'b0) begin
         n_err++;
         $display("FAIL alu_sub got lat=%0d lo=%h c=%b want 1 fffe 0", lat, bus.rsp_lo, bus.rsp_cout);
      end
      take_rsp();
      send(OP_ALU, ALU_AND, 1'b0, 16'hF0F0, 16'hFF00);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 1 || bus.rsp_lo !== 16'hF000) begin
         n_err++;
         $display("FAIL alu_and got lat=%0d lo=%h want 1 f000", lat, bus.rsp_lo);
      end
      take_rsp();
   endtask

   task automatic test_mul;
      int lat; logic rdy;
      send(OP_MUL, 3'b000, 1'b0, 16'hFFFF, 16'hFFFF);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 16 || {bus.rsp_hi, bus.rsp_lo} !== 32'hFFFE_0001 || bus.rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL mul_ffff got lat=%0d res=%h_%h e=%b want 16 fffe_0001 0", lat, bus.rsp_hi, bus.rsp_lo, bus.rsp_err);
      end
      n_cmp++;
      if (rdy !== 1'b0) begin
         n_err++;
         $display("FAIL mul_busy_ready got %b want 0", rdy);
      end
      take_rsp();
      send(OP_MUL, 3'b000, 1'b0, 16'h1234, 16'h0100);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 16 || {bus.rsp_hi, bus.rsp_lo} !== 32'h0012_3400 || bus.rsp_cout !== 1'b0) begin
         n_err++;
         $display("FAIL mul_shift got lat=%0d res=%h_%h c=%b want 16 0012_3400 0", lat, bus.rsp_hi, bus.rsp_lo, bus.rsp_cout);
      end
      take_rsp();
   endtask

   task automatic test_div;
      int lat; logic rdy;
      send(OP_DIV, 3'b000, 1'b0, 16'hFFFF, 16'h0007);
      wait_rsp(lat, rdy);
`ifdef ALU_SEQ_DIV_EN
      n_cmp++;
      if (lat !== 16 || bus.rsp_lo !== 16'h2492 || bus.rsp_hi !== 16'h0001 || bus.rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL div_7 got lat=%0d q=%h r=%h e=%b want 16 2492 0001 0", lat, bus.rsp_lo, bus.rsp_hi, bus.rsp_err);
      end
      take_rsp();
      send(OP_DIV, 3'b000, 1'b0, 16'h8000, 16'h8001);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 16 || bus.rsp_lo !== 16'h0000 || bus.rsp_hi !== 16'h8000) begin
         n_err++;
         $display("FAIL div_msb got lat=%0d q=%h r=%h want 16 0000 8000", lat, bus.rsp_lo, bus.rsp_hi);
      end
`else
      n_cmp++;
      if (lat !== 0 || bus.rsp_lo !== 16'h0000 || bus.rsp_hi !== 16'h0000 || bus.rsp_err !== 1'b1) begin
         n_err++;
         $display("FAIL div_disabled got lat=%0d lo=%h hi=%h e=%b want 0 0000 0000 1", lat, bus.rsp_lo, bus.rsp_hi, bus.rsp_err);
      end
`endif
      take_rsp();
      send(OP_DIV, 3'b000, 1'b0, 16'h1234, 16'h0000);
      wait_rsp(lat, rdy);
`ifdef ALU_SEQ_DIV_EN
      n_cmp++;
      if (lat !== 0 || bus.rsp_lo !== 16'hFFFF || bus.rsp_hi !== 16'h1234 || bus.rsp_err !== 1'b1) begin
         n_err++;
         $display("FAIL div_zero got lat=%0d lo=%h hi=%h e=%b want 0 ffff 1234 1", lat, bus.rsp_lo, bus.rsp_hi, bus.rsp_err);
      end
`else
      n_cmp++;
      if (lat !== 0 || bus.rsp_lo !== 16'h0000 || bus.rsp_hi !== 16'h0000 || bus.rsp_err !== 1'b1) begin
         n_err++;
         $display("FAIL div_zero got lat=%0d lo=%h hi=%h e=%b want 0 0000 0000 1", lat, bus.rsp_lo, bus.rsp_hi, bus.rsp_err);
      end
`endif
      take_rsp();
   endtask

   task automatic test_illegal;
      int lat; logic rdy;
      send(OP_ILL, 3'b010, 1'b1, 16'hABCD, 16'h1111);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 0 || bus.rsp_lo !== 16'h0000 || bus.rsp_hi !== 16'h0000 || bus.rsp_err !== 1'b1 || bus.rsp_cout !== 1'b0) begin
         n_err++;
         $display("FAIL illegal got lat=%0d lo=%h hi=%h e=%b c=%b want 0 0000 0000 1 0", lat, bus.rsp_lo, bus.rsp_hi, bus.rsp_err, bus.rsp_cout);
      end
      take_rsp();
   endtask

   task automatic test_hold;
      int lat; logic rdy;
      send(OP_MUL, 3'b000, 1'b0, 16'h0003, 16'h0005);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 16 || {bus.rsp_hi, bus.rsp_lo} !== 32'h0000_000F) begin
         n_err++;
         $display("FAIL hold_mul got lat=%0d res=%h_%h want 16 0000_000f", lat, bus.rsp_hi, bus.rsp_lo);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            bus.req_op = OP_ALU; bus.req_a = 16'h0001; bus.req_b = 16'h0001; bus.req_valid = 1'b1;
         end
         if (i == 3) bus.req_valid = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || {bus.rsp_hi, bus.rsp_lo} !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL hold_cycle%0d got v=%b rdy=%b res=%h_%h want 1 0 0000_000f", i, bus.rsp_valid, bus.req_ready, bus.rsp_hi, bus.rsp_lo);
         end
      end
      take_rsp();
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL hold_release got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic rdy;
      send(OP_ALU, ALU_XOR, 1'b0, 16'h00FF, 16'h0F0F);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 1 || bus.rsp_lo !== 16'h0FF0) begin
         n_err++;
         $display("FAIL b2b_xor got lat=%0d lo=%h want 1 0ff0", lat, bus.rsp_lo);
      end
      take_rsp();
      send(OP_ALU, ALU_OR, 1'b0, 16'h1200, 16'h0034);
      wait_rsp(lat, rdy);
      n_cmp++;
      if (lat !== 1 || bus.rsp_lo !== 16'h1234) begin
         n_err++;
         $display("FAIL b2b_or got lat=%0d lo=%h want 1 1234", lat, bus.rsp_lo);
      end
      take_rsp();
   endtask

   task automatic test_reset_mid;
      logic seen_valid;
      send(OP_MUL, 3'b000, 1'b0, 16'hFFFF, 16'hFFFF);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_cout, bus.rsp_lo, bus.rsp_hi} !== 35'd0 ||
          {alu_a, alu_b, alu_ctrl, alu_binv, alu_cin} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs got v=%b lo=%h hi=%h a=%h b=%h ctrl=%b want all 0", bus.rsp_valid, bus.rsp_lo, bus.rsp_hi, alu_a, alu_b, alu_ctrl);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | bus.rsp_valid;
      end
      n_cmp++;
      if (seen_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_abort got seen_valid=%b rdy=%b want 0 1", seen_valid, bus.req_ready);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_func  = 3'b000;
      bus.req_binv  = 1'b0;
      bus.req_a     = 16'h0000;
      bus.req_b     = 16'h0000;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_alu();
      test_mul();
      test_div();
      test_illegal();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
